// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and queue entry type for the writeback sequencer
package wb_pkg;
  localparam int WB_DEPTH_DEFAULT = 4;
  localparam logic [4:0] ZERO_REG_IDX = 5'd31;
  typedef struct packed {
    logic [4:0] rd;
    logic [63:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: producer channels, forwarding lookup and register file write port
//   master: drives mem_*/alu_* valid/reg/data and read1/read2; sees readies, fwd*, write port, count
//   slave : the writeback sequencer side of the same signals
interface regfile_writeback_if #(parameter int DEPTH = wb_pkg::WB_DEPTH_DEFAULT) ();
  logic mem_valid, mem_ready, alu_valid, alu_ready;
  logic [4:0] mem_reg, alu_reg, read1, read2, writeReg;
  logic [63:0] mem_data, alu_data, fwd1_data, fwd2_data, writeData;
  logic fwd1_hit, fwd2_hit, CONTROL_REGWRITE;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, read1, read2,
    input mem_ready, alu_ready, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
    input writeReg, writeData, CONTROL_REGWRITE, count
  );
  modport slave (
    input mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, read1, read2,
    output mem_ready, alu_ready, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
    output writeReg, writeData, CONTROL_REGWRITE, count
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of wb_entry_t with ordered dual push, single pop and youngest-match search
//   clk/rst: clock, sync active-high reset; push_a/entry_a older push, push_b/entry_b younger push
//   pop/head: remove oldest entry; count: occupancy; q*/hit*/data*: combinational youngest-match lookup
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_a,
  input  wb_entry_t entry_a,
  input  logic push_b,
  input  wb_entry_t entry_b,
  input  logic pop,
  output wb_entry_t head,
  output logic [CW-1:0] count,
  input  logic [4:0] q1,
  input  logic [4:0] q2,
  output logic hit1,
  output logic hit2,
  output logic [63:0] data1,
  output logic [63:0] data2
);
  wb_entry_t mem [DEPTH];
  wb_entry_t e;
  logic [AW-1:0] hd, tl;
  always_ff @(posedge clk) begin
    if (rst) begin
      hd <= '0;
      tl <= '0;
      count <= '0;
    end else begin
      hd <= hd + AW'(pop);
      tl <= tl + AW'(push_a) + AW'(push_b);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push_a) mem[tl] <= entry_a;
    if (push_b) mem[push_a ? tl + AW'(1) : tl] <= entry_b;
  end
  assign head = mem[hd];
  // walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    e = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    data1 = '0;
    data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e = mem[hd + AW'(i)];
      if (CW'(i) < count && e.rd == q1) begin
        hit1 = 1'b1;
        data1 = e.data;
      end
      if (CW'(i) < count && e.rd == q2) begin
        hit2 = 1'b1;
        data2 = e.data;
      end
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: queues ALU/load results and drains one per cycle into the register file write port
//   CLOCK/RESET: clock, sync active-high reset
//   bus (slave): mem_*/alu_* producer handshakes, read1/read2 forwarding lookup,
//                writeReg/writeData/CONTROL_REGWRITE registered write port, count occupancy
module regfile_writeback import wb_pkg::*; #(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  parameter logic [4:0] ZERO_REG = ZERO_REG_IDX,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic CLOCK,
  input logic RESET,
  regfile_writeback_if.slave bus
);
  logic [CW-1:0] cnt, free;
  logic push_a, push_b, pop, qh1, qh2, o1, o2, live1, live2;
  logic [63:0] qd1, qd2;
  wb_entry_t head;
  // readies look only at registered occupancy, ignoring the same-edge pop
  assign free = CW'(DEPTH) - cnt;
  assign bus.mem_ready = !RESET && free != '0;
  assign bus.alu_ready = !RESET && (free >= CW'(2) || (free != '0 && !bus.mem_valid));
  assign push_a = bus.mem_valid && bus.mem_ready && bus.mem_reg != ZERO_REG;
  assign push_b = bus.alu_valid && bus.alu_ready && bus.alu_reg != ZERO_REG;
  assign pop = cnt != '0;
  assign bus.count = cnt;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(CLOCK),
    .rst(RESET),
    .push_a(push_a),
    .entry_a({bus.mem_reg, bus.mem_data}),
    .push_b(push_b),
    .entry_b({bus.alu_reg, bus.alu_data}),
    .pop(pop),
    .head(head),
    .count(cnt),
    .q1(bus.read1),
    .q2(bus.read2),
    .hit1(qh1),
    .hit2(qh2),
    .data1(qd1),
    .data2(qd2)
  );
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      bus.CONTROL_REGWRITE <= 1'b0;
      bus.writeReg <= '0;
      bus.writeData <= '0;
    end else begin
      bus.CONTROL_REGWRITE <= pop;
      if (pop) {bus.writeReg, bus.writeData} <= head;
    end
  end
  // queued entries are younger than the output stage, so they take priority
  assign o1 = bus.CONTROL_REGWRITE && bus.writeReg == bus.read1;
  assign o2 = bus.CONTROL_REGWRITE && bus.writeReg == bus.read2;
  assign live1 = !RESET && bus.read1 != ZERO_REG;
  assign live2 = !RESET && bus.read2 != ZERO_REG;
  assign bus.fwd1_hit = live1 && (qh1 || o1);
  assign bus.fwd2_hit = live2 && (qh2 || o2);
  assign bus.fwd1_data = !live1 ? '0 : qh1 ? qd1 : o1 ? bus.writeData : '0;
  assign bus.fwd2_data = !live2 ? '0 : qh2 ? qd2 : o2 ? bus.writeData : '0;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vector table plus randomized traffic against a queue-based reference model
module tb_regfile_writeback;
  import wb_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_writeback_if #(.DEPTH(DEPTH)) bus ();
  regfile_writeback #(.DEPTH(DEPTH)) dut (.CLOCK(clk), .RESET(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  wb_entry_t mq[$];
  logic m_we = 1'b0;
  logic [4:0] m_wr = '0;
  logic [63:0] m_wd = '0;
  logic last_mx, last_ax;
  typedef struct {
    logic mv; logic [4:0] mr; logic [63:0] md;
    logic av; logic [4:0] ar; logic [63:0] ad;
    logic [4:0] r1, r2;
    logic emr, ear, e1h; logic [63:0] e1d; logic e2h; logic [63:0] e2d;
    logic ewe; logic [4:0] ewr; logic [63:0] ewd; int ecnt;
  } vec_t;
  vec_t tv[9];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic m_mr();
    return !rst && mq.size() < DEPTH;
  endfunction
  function automatic logic m_ar(logic mv);
    int f = DEPTH - mq.size();
    return !rst && (f >= 2 || (f >= 1 && !mv));
  endfunction
  function automatic logic [64:0] m_fwd(logic [4:0] r);
    if (rst || r == ZERO_REG_IDX) return '0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rd == r) return {1'b1, mq[i].data};
    if (m_we && m_wr == r) return {1'b1, m_wd};
    return '0;
  endfunction
  task automatic model_edge();
    wb_entry_t h;
    last_mx = bus.mem_valid && m_mr();
    last_ax = bus.alu_valid && m_ar(bus.mem_valid);
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_wr = '0; m_wd = '0;
    end else begin
      m_we = mq.size() != 0;
      if (m_we) begin
        h = mq.pop_front();
        m_wr = h.rd; m_wd = h.data;
      end
      if (last_mx && bus.mem_reg != ZERO_REG_IDX) mq.push_back({bus.mem_reg, bus.mem_data});
      if (last_ax && bus.alu_reg != ZERO_REG_IDX) mq.push_back({bus.alu_reg, bus.alu_data});
    end
  endtask
  task automatic drive(logic mv, logic [4:0] mr, logic [63:0] md, logic av, logic [4:0] ar,
                       logic [63:0] ad, logic [4:0] r1, logic [4:0] r2, logic rs);
    bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
    bus.read1 = r1; bus.read2 = r2; rst = rs;
  endtask
  task automatic cyc(logic mv, logic [4:0] mr, logic [63:0] md, logic av, logic [4:0] ar,
                     logic [63:0] ad, logic [4:0] r1, logic [4:0] r2, logic rs);
    logic [64:0] f1, f2;
    drive(mv, mr, md, av, ar, ad, r1, r2, rs);
    #1;
    f1 = m_fwd(r1);
    f2 = m_fwd(r2);
    chk("mem_ready", bus.mem_ready, m_mr());
    chk("alu_ready", bus.alu_ready, m_ar(mv));
    chk("fwd1_hit", bus.fwd1_hit, f1[64]);
    chk("fwd1_data", bus.fwd1_data, f1[63:0]);
    chk("fwd2_hit", bus.fwd2_hit, f2[64]);
    chk("fwd2_data", bus.fwd2_data, f2[63:0]);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("regwrite", bus.CONTROL_REGWRITE, m_we);
    chk("writeReg", bus.writeReg, m_wr);
    chk("writeData", bus.writeData, m_wd);
    chk("count", bus.count, mq.size());
    chk("count_le_depth", bus.count <= DEPTH, 1);
  endtask
  function automatic logic [4:0] pick();
    return ($urandom_range(0, 7) == 0) ? ZERO_REG_IDX : 5'($urandom_range(0, 6));
  endfunction
  logic cmv, cav;
  logic [4:0] cmr, car;
  logic [63:0] cmd, cad;
  task automatic rand_cyc(logic force_v, int rst_odds);
    if (!(cmv && !last_mx)) begin
      cmv = force_v || $urandom_range(0, 9) < 6;
      cmr = pick(); cmd = {$urandom, $urandom};
    end
    if (!(cav && !last_ax)) begin
      cav = force_v || $urandom_range(0, 9) < 6;
      car = pick(); cad = {$urandom, $urandom};
    end
    cyc(cmv, cmr, cmd, cav, car, cad, pick(), pick(), rst_odds != 0 && $urandom_range(0, rst_odds) == 0);
  endtask
  initial begin
    tv[0] = '{0, 0, 0, 1, 5, 64'hDEAD, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    tv[1] = '{0, 0, 0, 0, 0, 0, 5, 5, 1, 1, 1, 64'hDEAD, 1, 64'hDEAD, 1, 5, 64'hDEAD, 0};
    tv[2] = '{0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 1, 64'hDEAD, 0, 0, 0, 5, 64'hDEAD, 0};
    tv[3] = '{1, 3, 64'h11, 1, 3, 64'h22, 3, 0, 1, 1, 0, 0, 0, 0, 0, 5, 64'hDEAD, 2};
    tv[4] = '{0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 64'h22, 0, 0, 1, 3, 64'h11, 1};
    tv[5] = '{0, 0, 0, 0, 0, 0, 3, 3, 1, 1, 1, 64'h22, 1, 64'h22, 1, 3, 64'h22, 0};
    tv[6] = '{0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 64'h22, 0, 0, 0, 3, 64'h22, 0};
    tv[7] = '{0, 0, 0, 1, 31, 64'hFF, 31, 0, 1, 1, 0, 0, 0, 0, 0, 3, 64'h22, 0};
    tv[8] = '{0, 0, 0, 0, 0, 0, 31, 3, 1, 1, 0, 0, 0, 0, 0, 3, 64'h22, 0};
    cmv = 0; cav = 0; cmr = 0; car = 0; cmd = 0; cad = 0;
    last_mx = 0; last_ax = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 1);
    for (int i = 0; i < 9; i++) begin
      drive(tv[i].mv, tv[i].mr, tv[i].md, tv[i].av, tv[i].ar, tv[i].ad, tv[i].r1, tv[i].r2, 0);
      #1;
      chk($sformatf("v%0d.mem_ready", i), bus.mem_ready, tv[i].emr);
      chk($sformatf("v%0d.alu_ready", i), bus.alu_ready, tv[i].ear);
      chk($sformatf("v%0d.fwd1_hit", i), bus.fwd1_hit, tv[i].e1h);
      chk($sformatf("v%0d.fwd1_data", i), bus.fwd1_data, tv[i].e1d);
      chk($sformatf("v%0d.fwd2_hit", i), bus.fwd2_hit, tv[i].e2h);
      chk($sformatf("v%0d.fwd2_data", i), bus.fwd2_data, tv[i].e2d);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk($sformatf("v%0d.regwrite", i), bus.CONTROL_REGWRITE, tv[i].ewe);
      chk($sformatf("v%0d.writeReg", i), bus.writeReg, tv[i].ewr);
      chk($sformatf("v%0d.writeData", i), bus.writeData, tv[i].ewd);
      chk($sformatf("v%0d.count", i), bus.count, tv[i].ecnt);
    end
    cyc(1, 1, 64'hA1, 1, 2, 64'hA2, 4, 1, 0);
    cyc(1, 4, 64'hB4, 1, 6, 64'hB6, 4, 1, 0);
    chk("midrst.filled", bus.count, 3);
    cyc(0, 0, 0, 0, 0, 0, 4, 6, 1);
    chk("midrst.count", bus.count, 0);
    chk("midrst.regwrite", bus.CONTROL_REGWRITE, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 4, 6, 0);
    last_mx = 0; last_ax = 0;
    for (int i = 0; i < 60; i++) rand_cyc(1, 0);
    for (int i = 0; i < 800; i++) rand_cyc(0, 150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
